// File: rtl/psram_mem_model.sv
// PSRAM serial responder: SPI/QPI command, address, wait and data phases over an internal byte array.
// Pins oversampled in clk_i (about 3 clk_i from pin edge to action); no backpressure, it follows the bus.
module psram_mem_model #(
    parameter int MEM_AW   = 10,
    parameter int WAIT_CYC = 6,
    parameter bit INIT_QPI = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_n_i,
    input  logic [3:0] psram_sio_i,
    output logic [3:0] psram_sio_o,
    output logic [3:0] psram_sio_oe_o,
    output logic       qpi_mode_o,
    output logic       busy_o,
    output logic       err_o
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, ILLEGAL} state_t;

    // Shift register only needs the bits that feed the command decode or the pointer
    localparam int SW = (MEM_AW > 8) ? MEM_AW : 8;

    state_t            state, state_nx;
    logic              sck_s1, sck_s2, sck_s3, ce_s1, ce_s2;
    logic [3:0]        sio_s1, sio_s2;
    logic              rise, fall;
    logic [7:0]        mem [2**MEM_AW];
    logic [SW-2:0]     sh;
    logic [SW-1:0]     sh_nx;
    logic [4:0]        cnt, cnt_nx;
    logic [7:0]        wait_cnt, rbyte;
    logic [MEM_AW-1:0] ptr, ptr_inc, addr_ptr;
    logic              is_write, rd_wait, qpi_off;
    logic              cmd_done, cmd_wr, cmd_wait, go_qpi, arm_off, bad_cmd, mem_we;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            ce_s1  <= 1'b1;
            ce_s2  <= 1'b1;
            sio_s1 <= 4'h0;
            sio_s2 <= 4'h0;
        end else begin
            sck_s1 <= psram_sck_i;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            ce_s1  <= psram_ce_n_i;
            ce_s2  <= ce_s1;
            sio_s1 <= psram_sio_i;
            sio_s2 <= sio_s1;
        end
    end

    assign rise     = sck_s2 & ~sck_s3;
    assign fall     = ~sck_s2 & sck_s3;
    assign sh_nx    = qpi_mode_o ? {sh[SW-5:0], sio_s2} : {sh, sio_s2[0]};
    assign cnt_nx   = cnt + (qpi_mode_o ? 5'd4 : 5'd1);
    assign ptr_inc  = ptr + 1'b1;
    assign addr_ptr = sh_nx[MEM_AW-1:0];
    assign busy_o   = (state != IDLE) && !ce_s2;
    assign mem_we   = !rst_i && !ce_s2 && (state == WDATA) && rise && (cnt_nx == 5'd8);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cmd_done = 1'b0;
        cmd_wr   = 1'b0;
        cmd_wait = 1'b0;
        go_qpi   = 1'b0;
        arm_off  = 1'b0;
        bad_cmd  = 1'b0;
        if (ce_s2) begin
            state_nx = IDLE;
        end else begin
            case (state)
                // IDLE shares CMD handling so a rise coincident with CE fall is bit 7
                IDLE, CMD: begin
                    state_nx = CMD;
                    if (rise && cnt_nx == 5'd8) begin
                        cmd_done = 1'b1;
                        state_nx = ADDR;
                        if (!qpi_mode_o) begin
                            case (sh_nx[7:0])
                                8'h03:   ;
                                8'h02:   cmd_wr = 1'b1;
                                8'h35:   begin go_qpi = 1'b1; state_nx = ILLEGAL; end
                                default: begin bad_cmd = 1'b1; state_nx = ILLEGAL; end
                            endcase
                        end else begin
                            case (sh_nx[7:0])
                                8'hEB:   cmd_wait = 1'b1;
                                8'h38:   cmd_wr = 1'b1;
                                8'hF5:   begin arm_off = 1'b1; state_nx = ILLEGAL; end
                                default: begin bad_cmd = 1'b1; state_nx = ILLEGAL; end
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (rise && cnt_nx == 5'd24) begin
                        if (is_write)                     state_nx = WDATA;
                        else if (rd_wait && WAIT_CYC > 0) state_nx = WAIT;
                        else                              state_nx = RDATA;
                    end
                end
                WAIT: begin
                    if (rise && wait_cnt == 8'(WAIT_CYC - 1)) state_nx = RDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[ptr] <= sh_nx[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psram_sio_o    <= 4'h0;
            psram_sio_oe_o <= 4'h0;
            qpi_mode_o     <= INIT_QPI;
            err_o          <= 1'b0;
            sh             <= '0;
            cnt            <= 5'd0;
            wait_cnt       <= 8'd0;
            rbyte          <= 8'h00;
            ptr            <= '0;
            is_write       <= 1'b0;
            rd_wait        <= 1'b0;
            qpi_off        <= 1'b0;
        end else begin
            err_o <= bad_cmd;
            if (go_qpi)  qpi_mode_o <= 1'b1;
            if (arm_off) qpi_off    <= 1'b1;
            if (ce_s2) begin
                // Mode exit takes effect only once the F5 transaction closes
                psram_sio_oe_o <= 4'h0;
                cnt            <= 5'd0;
                wait_cnt       <= 8'd0;
                qpi_off        <= 1'b0;
                if (qpi_off) qpi_mode_o <= 1'b0;
            end else begin
                case (state)
                    IDLE, CMD: begin
                        if (rise) begin
                            sh  <= sh_nx[SW-2:0];
                            cnt <= (cnt_nx == 5'd8) ? 5'd0 : cnt_nx;
                        end
                        if (cmd_done) begin
                            is_write <= cmd_wr;
                            rd_wait  <= cmd_wait;
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            sh <= sh_nx[SW-2:0];
                            if (cnt_nx == 5'd24) begin
                                cnt   <= 5'd0;
                                ptr   <= addr_ptr;
                                rbyte <= mem[addr_ptr];
                            end else begin
                                cnt <= cnt_nx;
                            end
                        end
                    end
                    WAIT: begin
                        if (rise) wait_cnt <= wait_cnt + 8'd1;
                    end
                    RDATA: begin
                        if (fall) begin
                            psram_sio_oe_o <= qpi_mode_o ? 4'b1111 : 4'b0010;
                            psram_sio_o    <= qpi_mode_o ? rbyte[7:4] : {2'b00, rbyte[7], 1'b0};
                            if (cnt_nx == 5'd8) begin
                                cnt   <= 5'd0;
                                ptr   <= ptr_inc;
                                rbyte <= mem[ptr_inc];
                            end else begin
                                cnt   <= cnt_nx;
                                rbyte <= qpi_mode_o ? {rbyte[3:0], 4'h0} : {rbyte[6:0], 1'b0};
                            end
                        end
                    end
                    WDATA: begin
                        if (rise) begin
                            sh <= sh_nx[SW-2:0];
                            if (cnt_nx == 5'd8) begin
                                cnt <= 5'd0;
                                ptr <= ptr_inc;
                            end else begin
                                cnt <= cnt_nx;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
